// File: rtl/bq_coeff_loader.sv
// bq_coeff_loader
// Wishbone initiator that streams NCOEF biquad coefficients into a biquad
// coefficient target, one single-beat classic write per coefficient, with
// retry/backoff handling, a per-beat bus timeout and completion reporting.
// Optional feature macro: BQ_LOADER_READBACK_EN adds a read-back and compare
// of every written coefficient.

module bq_coeff_loader #(
    parameter int NCOEF     = 14,
    parameter int ADR_STEP  = 4,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    input  logic [21:0] base_adr_i,
    input  logic [31:0] coef_dat_i,
    input  logic        coef_valid_i,
    output logic        coef_ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  err_code_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [21:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    localparam logic [6:0]  IDX_LAST  = 7'(NCOEF - 1);
    localparam logic [21:0] STEP_W    = 22'(ADR_STEP);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_BUS     = 3'd1;
    localparam logic [2:0] ERR_RETRY   = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
`ifdef BQ_LOADER_READBACK_EN
    localparam logic [2:0] ERR_CMP     = 3'd4;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WRITE   = 3'd2,
        S_BACKOFF = 3'd3,
`ifdef BQ_LOADER_READBACK_EN
        S_READ    = 3'd4,
`endif
        S_DONE    = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [21:0] adr_q;
    logic [31:0] coef_q;
    logic [6:0]  idx_q;
    logic [15:0] tmo_q;
    logic [7:0]  rty_q;
    logic [2:0]  err_q;

    logic        is_last;
    logic        tmo_hit;
    logic        rty_over;

`ifdef BQ_LOADER_READBACK_EN
    logic        rd_phase_q;
    logic        rd_match;
`else
    logic        unused_rd_dat;
`endif

    assign is_last  = (idx_q == IDX_LAST);
    assign tmo_hit  = (tmo_q == TMO_LAST);
    assign rty_over = (rty_q >= RETRY_MAX);

`ifdef BQ_LOADER_READBACK_EN
    assign rd_match = (wb_dat_i == coef_q);
`else
    assign unused_rd_dat = ^wb_dat_i;
`endif

    // State register; an asynchronous reset abandons any beat in flight.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; bus responses are ranked err > rty > ack > timeout.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start_i) next_state = S_FETCH;
            end
            S_FETCH: begin
                if (coef_valid_i) next_state = S_WRITE;
            end
            S_WRITE: begin
                if (wb_err_i) begin
                    next_state = S_DONE;
                end else if (wb_rty_i) begin
                    next_state = rty_over ? S_DONE : S_BACKOFF;
                end else if (wb_ack_i) begin
`ifdef BQ_LOADER_READBACK_EN
                    next_state = S_BACKOFF;
`else
                    next_state = is_last ? S_DONE : S_FETCH;
`endif
                end else if (tmo_hit) begin
                    next_state = S_DONE;
                end
            end
            S_BACKOFF: begin
`ifdef BQ_LOADER_READBACK_EN
                next_state = rd_phase_q ? S_READ : S_WRITE;
`else
                next_state = S_WRITE;
`endif
            end
`ifdef BQ_LOADER_READBACK_EN
            S_READ: begin
                if (wb_err_i) begin
                    next_state = S_DONE;
                end else if (wb_rty_i) begin
                    next_state = rty_over ? S_DONE : S_BACKOFF;
                end else if (wb_ack_i) begin
                    next_state = (!rd_match || is_last) ? S_DONE : S_FETCH;
                end else if (tmo_hit) begin
                    next_state = S_DONE;
                end
            end
`endif
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Beat bookkeeping: address/index walk, captured word, retry and timeout counters, result code.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            adr_q      <= '0;
            coef_q     <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            rty_q      <= '0;
            err_q      <= ERR_OK;
`ifdef BQ_LOADER_READBACK_EN
            rd_phase_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        adr_q <= base_adr_i;
                        idx_q <= '0;
                        rty_q <= '0;
                        tmo_q <= '0;
                        err_q <= ERR_OK;
                    end
                end
                S_FETCH: begin
                    if (coef_valid_i) begin
                        coef_q     <= coef_dat_i;
                        rty_q      <= '0;
                        tmo_q      <= '0;
`ifdef BQ_LOADER_READBACK_EN
                        rd_phase_q <= 1'b0;
`endif
                    end
                end
                S_WRITE: begin
                    if (wb_err_i) begin
                        err_q <= ERR_BUS;
                    end else if (wb_rty_i) begin
                        tmo_q <= '0;
                        if (rty_over) err_q <= ERR_RETRY;
                        else          rty_q <= rty_q + 8'd1;
                    end else if (wb_ack_i) begin
                        tmo_q <= '0;
`ifdef BQ_LOADER_READBACK_EN
                        rty_q      <= '0;
                        rd_phase_q <= 1'b1;
`else
                        idx_q <= idx_q + 7'd1;
                        adr_q <= adr_q + STEP_W;
`endif
                    end else if (tmo_hit) begin
                        err_q <= ERR_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
`ifdef BQ_LOADER_READBACK_EN
                S_READ: begin
                    if (wb_err_i) begin
                        err_q <= ERR_BUS;
                    end else if (wb_rty_i) begin
                        tmo_q <= '0;
                        if (rty_over) err_q <= ERR_RETRY;
                        else          rty_q <= rty_q + 8'd1;
                    end else if (wb_ack_i) begin
                        tmo_q <= '0;
                        if (!rd_match) begin
                            err_q <= ERR_CMP;
                        end else begin
                            idx_q      <= idx_q + 7'd1;
                            adr_q      <= adr_q + STEP_W;
                            rd_phase_q <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        err_q <= ERR_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Moore outputs decoded from the current state only.
    always_comb begin
        coef_ready_o = 1'b0;
        done_o       = 1'b0;
        wb_cyc_o     = 1'b0;
        wb_stb_o     = 1'b0;
        wb_we_o      = 1'b0;
        wb_adr_o     = '0;
        wb_dat_o     = '0;
        busy_o       = (state != S_IDLE);
        case (state)
            S_FETCH: begin
                coef_ready_o = 1'b1;
            end
            S_WRITE: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = 1'b1;
                wb_adr_o = adr_q;
                wb_dat_o = coef_q;
            end
`ifdef BQ_LOADER_READBACK_EN
            S_READ: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_adr_o = adr_q;
            end
`endif
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign err_code_o = err_q;
    assign wb_sel_o   = 4'hF;

endmodule
